// File: rtl/mem_l2cache_responder_pkg.sv
// Shared types and sizing for the L2 memory-side responder.
package mem_l2cache_responder_pkg;

    // Transaction FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RD_ISSUE,
        ST_RD_DRAIN,
        ST_RESP,
        ST_WR
    } state_e;

    localparam int DEF_OFFSET_WIDTH = 3;
    // Line width for the default build: 32 bits per word, 2^OFFSET_WIDTH words
    localparam int W = 32 << DEF_OFFSET_WIDTH;
    // Wait counter width: EXTRA_LAT (max 15) plus an optional 3-bit random term
    localparam int WAIT_CNT_W = 5;

    // Line width for an arbitrary OFFSET_WIDTH
    function automatic int line_w(input int offset_width);
        return 32 << offset_width;
    endfunction

endpackage

// File: rtl/mem_l2cache_beat_ctr.sv
// Latency countdown, beat index and last-beat flag for the responder.
// Optional macro L2MEM_RAND_LAT_EN adds an 8-bit LFSR that lengthens the
// wait phase by a pseudo-random 0..7 cycles per accepted request.
module mem_l2cache_beat_ctr
    import mem_l2cache_responder_pkg::*;
#(
    parameter int OFFSET_WIDTH = 3,
    parameter int EXTRA_LAT    = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    accept,
    input  logic                    in_wait,
    input  logic                    in_beat,
    input  logic                    suc,
    output logic [OFFSET_WIDTH-1:0] k,
    output logic                    last_beat,
    output logic                    skip_wait,
    output logic                    wait_last
);

    logic [WAIT_CNT_W-1:0] wait_len;
    logic [WAIT_CNT_W-1:0] wait_cnt;

`ifdef L2MEM_RAND_LAT_EN
    logic [7:0] lfsr;

    // LFSR x^8+x^6+x^5+x^4+1, advanced once per accepted request
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lfsr <= 8'hA5;
        end else if (accept) begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
        end
    end

    assign wait_len = WAIT_CNT_W'(EXTRA_LAT) + WAIT_CNT_W'(lfsr[2:0]);
`else
    assign wait_len = WAIT_CNT_W'(EXTRA_LAT);
`endif

    // A zero-length wait lets the FSM go straight to the RAM beats
    assign skip_wait = (wait_len == '0);
    assign wait_last = (wait_cnt == WAIT_CNT_W'(1));
    // Uncached accesses are a single beat; line accesses end on the top lane
    assign last_beat = suc || (&k);

    // Load the wait length at acceptance, then count down wait cycles and up beats
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt <= '0;
            k        <= '0;
        end else if (accept) begin
            wait_cnt <= wait_len;
            k        <= '0;
        end else begin
            if (in_wait) wait_cnt <= wait_cnt - 1'b1;
            if (in_beat) k <= k + 1'b1;
        end
    end

endmodule

// File: rtl/mem_l2cache_responder.sv
// Memory-side responder for the L2 refill/write-back port. Accepts one read
// or write at a time on the addrOK/dataOK handshake and executes it as
// word-by-word accesses to a synchronous single-port RAM (1-cycle read).
// Optional macro L2MEM_RAND_LAT_EN randomises the pre-access wait.
module mem_l2cache_responder
    import mem_l2cache_responder_pkg::*;
#(
    parameter int OFFSET_WIDTH = 3,
    parameter int ADDR_W       = 16,
    parameter int EXTRA_LAT    = 2
) (
    input  logic                            clk,
    input  logic                            rstn,
    input  logic [31:0]                     addr_l2cache_mem_r,
    input  logic [31:0]                     addr_l2cache_mem_w,
    input  logic [line_w(OFFSET_WIDTH)-1:0] dout_l2cache_mem,
    output logic [line_w(OFFSET_WIDTH)-1:0] din_mem_l2cache,
    input  logic                            l2cache_mem_req_r,
    input  logic                            l2cache_mem_req_w,
    input  logic                            l2cache_mem_rdy,
    input  logic                            l2cache_mem_SUC,
    input  logic [3:0]                      l2cache_mem_wstrb,
    input  logic [1:0]                      l2cache_mem_size,
    output logic                            mem_l2cache_addrOK_r,
    output logic                            mem_l2cache_addrOK_w,
    output logic                            mem_l2cache_dataOK,
    output logic                            ram_en,
    output logic [3:0]                      ram_we,
    output logic [ADDR_W-1:0]               ram_addr,
    output logic [31:0]                     ram_wdata,
    input  logic [31:0]                     ram_rdata
);

    localparam int LW = line_w(OFFSET_WIDTH);

    state_e                  state;
    logic                    run_q;
    logic [ADDR_W-1:0]       base_q;
    logic                    suc_q;
    logic [3:0]              wstrb_q;
    logic                    is_wr_q;
    logic [LW-1:0]           line_q;
    logic                    cap_pend;
    logic [OFFSET_WIDTH-1:0] cap_idx;

    logic [OFFSET_WIDTH-1:0] k;
    logic                    last_beat;
    logic                    skip_wait;
    logic                    wait_last;
    logic                    acc_w;
    logic                    acc_r;
    logic                    accept;
    logic                    in_wait;
    logic                    in_beat;

    // Size and the address bits outside the RAM window are deliberately ignored
    logic unused_bits;
    assign unused_bits = ^{l2cache_mem_size,
                           addr_l2cache_mem_r[31:ADDR_W+2], addr_l2cache_mem_r[1:0],
                           addr_l2cache_mem_w[31:ADDR_W+2], addr_l2cache_mem_w[1:0]};

    // RAM word address of the first beat: line-aligned unless uncached
    function automatic logic [ADDR_W-1:0] base_of(input logic [31:0] a, input logic suc);
        logic [ADDR_W-1:0] w;
        w = a[ADDR_W+1:2];
        if (!suc) w[OFFSET_WIDTH-1:0] = '0;
        return w;
    endfunction

    // Writes win a simultaneous request so a victim leaves before its refill
    assign acc_w   = run_q && (state == ST_IDLE) && l2cache_mem_req_w;
    assign acc_r   = run_q && (state == ST_IDLE) && l2cache_mem_req_r && !l2cache_mem_req_w;
    assign accept  = acc_w || acc_r;
    assign in_wait = (state == ST_WAIT);
    assign in_beat = (state == ST_RD_ISSUE) || (state == ST_WR);

    mem_l2cache_beat_ctr #(
        .OFFSET_WIDTH (OFFSET_WIDTH),
        .EXTRA_LAT    (EXTRA_LAT)
    ) u_beat_ctr (
        .clk       (clk),
        .rstn      (rstn),
        .accept    (accept),
        .in_wait   (in_wait),
        .in_beat   (in_beat),
        .suc       (suc_q),
        .k         (k),
        .last_beat (last_beat),
        .skip_wait (skip_wait),
        .wait_last (wait_last)
    );

    // Transaction FSM with the latched request and the line buffer
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            run_q    <= 1'b0;
            base_q   <= '0;
            suc_q    <= 1'b0;
            wstrb_q  <= '0;
            is_wr_q  <= 1'b0;
            // NOTE: the line buffer is reset even though it is storage, because
            // it drives din_mem_l2cache directly and must read as zero after reset.
            line_q   <= '0;
            cap_pend <= 1'b0;
            cap_idx  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register sees
            // the pre-edge values and the later line_q write below wins cleanly.
            run_q    <= 1'b1;
            cap_pend <= 1'b0;
            // RAM data returns one cycle after its issue beat
            if (cap_pend) line_q[cap_idx*32 +: 32] <= ram_rdata;

            unique case (state)
                ST_IDLE: begin
                    if (acc_w) begin
                        base_q  <= base_of(addr_l2cache_mem_w, l2cache_mem_SUC);
                        suc_q   <= l2cache_mem_SUC;
                        wstrb_q <= l2cache_mem_wstrb;
                        is_wr_q <= 1'b1;
                        line_q  <= dout_l2cache_mem;
                        state   <= skip_wait ? ST_WR : ST_WAIT;
                    end else if (acc_r) begin
                        base_q  <= base_of(addr_l2cache_mem_r, l2cache_mem_SUC);
                        suc_q   <= l2cache_mem_SUC;
                        wstrb_q <= '0;
                        is_wr_q <= 1'b0;
                        // Clearing here leaves lanes 1..N-1 zero for uncached reads
                        line_q  <= '0;
                        state   <= skip_wait ? ST_RD_ISSUE : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_last) state <= is_wr_q ? ST_WR : ST_RD_ISSUE;
                end
                ST_RD_ISSUE: begin
                    cap_pend <= 1'b1;
                    cap_idx  <= k;
                    if (last_beat) state <= ST_RD_DRAIN;
                end
                ST_RD_DRAIN: begin
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    if (l2cache_mem_rdy) state <= ST_IDLE;
                end
                ST_WR: begin
                    if (last_beat) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Handshake pulses are decoded from state and the live request/rdy inputs
    assign mem_l2cache_addrOK_w = acc_w;
    assign mem_l2cache_addrOK_r = acc_r;
    assign mem_l2cache_dataOK   = (state == ST_RESP) && l2cache_mem_rdy;
    assign din_mem_l2cache      = line_q;

    // RAM port: active only in the issue and write beats
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        ram_en    = 1'b0;
        ram_we    = 4'h0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (in_beat) begin
            ram_en   = 1'b1;
            ram_addr = base_q + ADDR_W'(k);
        end
        if (state == ST_WR) begin
            ram_we    = suc_q ? wstrb_q : 4'hF;
            ram_wdata = line_q[k*32 +: 32];
        end
    end

endmodule

// File: tb/tb_mem_l2cache_responder.sv
// Self-checking bench for mem_l2cache_responder (default build, macro undefined).
`timescale 1ns/1ps
module tb_mem_l2cache_responder;
    import mem_l2cache_responder_pkg::*;

    localparam int OW = DEF_OFFSET_WIDTH;
    localparam int AW = 16;
    localparam int EL = 2;
    localparam int N  = 1 << OW;
    localparam int LW = W;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [31:0]   addr_l2cache_mem_r = '0;
    logic [31:0]   addr_l2cache_mem_w = '0;
    logic [LW-1:0] dout_l2cache_mem = '0;
    logic [LW-1:0] din_mem_l2cache;
    logic          l2cache_mem_req_r = 1'b0;
    logic          l2cache_mem_req_w = 1'b0;
    logic          l2cache_mem_rdy = 1'b1;
    logic          l2cache_mem_SUC = 1'b0;
    logic [3:0]    l2cache_mem_wstrb = '0;
    logic [1:0]    l2cache_mem_size = 2'd2;
    logic          mem_l2cache_addrOK_r;
    logic          mem_l2cache_addrOK_w;
    logic          mem_l2cache_dataOK;
    logic          ram_en;
    logic [3:0]    ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int dual_cnt = 0;

    always #5 clk = ~clk;

    mem_l2cache_responder #(.OFFSET_WIDTH(OW), .ADDR_W(AW), .EXTRA_LAT(EL)) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .addr_l2cache_mem_r   (addr_l2cache_mem_r),
        .addr_l2cache_mem_w   (addr_l2cache_mem_w),
        .dout_l2cache_mem     (dout_l2cache_mem),
        .din_mem_l2cache      (din_mem_l2cache),
        .l2cache_mem_req_r    (l2cache_mem_req_r),
        .l2cache_mem_req_w    (l2cache_mem_req_w),
        .l2cache_mem_rdy      (l2cache_mem_rdy),
        .l2cache_mem_SUC      (l2cache_mem_SUC),
        .l2cache_mem_wstrb    (l2cache_mem_wstrb),
        .l2cache_mem_size     (l2cache_mem_size),
        .mem_l2cache_addrOK_r (mem_l2cache_addrOK_r),
        .mem_l2cache_addrOK_w (mem_l2cache_addrOK_w),
        .mem_l2cache_dataOK   (mem_l2cache_dataOK),
        .ram_en               (ram_en),
        .ram_we               (ram_we),
        .ram_addr             (ram_addr),
        .ram_wdata            (ram_wdata),
        .ram_rdata            (ram_rdata)
    );

    // Synchronous single-port RAM seen by the DUT
    logic [31:0] tb_ram  [0:(1<<AW)-1];
    // Reference memory, updated only by transaction-level rules
    logic [31:0] ref_mem [0:(1<<AW)-1];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we == 4'h0) ram_rdata <= tb_ram[ram_addr];
            else for (int b = 0; b < 4; b++)
                if (ram_we[b]) tb_ram[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    typedef struct { int c; logic [AW-1:0] a; logic [3:0] we; logic [31:0] d; } acc_t;
    acc_t log_q[$];

    always @(negedge clk) begin
        if (ram_en) log_q.push_back('{cyc, ram_addr, ram_we, ram_wdata});
        if (mem_l2cache_addrOK_r && mem_l2cache_addrOK_w) dual_cnt <= dual_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_line(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int m_base(input logic [31:0] a, input bit suc);
        int w;
        w = int'(a >> 2) % (1 << AW);
        if (!suc) w = w - (w % N);
        return w;
    endfunction

    function automatic void m_write(input logic [31:0] a, input bit suc,
                                    input logic [3:0] strb, input logic [LW-1:0] line);
        int b;
        b = m_base(a, suc);
        if (suc) begin
            for (int i = 0; i < 4; i++)
                if (strb[i]) ref_mem[b][8*i +: 8] = line[8*i +: 8];
        end else begin
            for (int j = 0; j < N; j++) ref_mem[b + j] = line[32*j +: 32];
        end
    endfunction

    function automatic logic [LW-1:0] m_read(input logic [31:0] a, input bit suc);
        logic [LW-1:0] l;
        int b;
        l = '0;
        b = m_base(a, suc);
        if (suc) l[31:0] = ref_mem[b];
        else for (int j = 0; j < N; j++) l[32*j +: 32] = ref_mem[b + j];
        return l;
    endfunction

    // ---------------- drivers ----------------
    task automatic wait_addrok(input bit wr, output int t0);
        bit got;
        got = 0;
        t0  = -1;
        for (int n = 0; n < 100 && !got; n++) begin
            @(negedge clk);
            if (wr ? mem_l2cache_addrOK_w : mem_l2cache_addrOK_r) begin
                got = 1;
                t0  = cyc;
            end
            @(posedge clk); #1;
        end
        check(wr ? "addrok_w_seen" : "addrok_r_seen", 32'(got), 32'd1);
    endtask

    task automatic wait_dataok(input int t0, input int m, input int hold,
                               output logic [LW-1:0] line, output int td);
        bit got;
        int lowcnt;
        logic [LW-1:0] snap;
        got    = 0;
        lowcnt = 0;
        snap   = '0;
        td     = -1;
        line   = '0;
        l2cache_mem_rdy = (hold == 0);
        for (int n = 0; n < 300 && !got; n++) begin
            @(negedge clk);
            if (mem_l2cache_dataOK) begin
                got  = 1;
                td   = cyc;
                line = din_mem_l2cache;
            end else if (!l2cache_mem_rdy && (cyc - t0) >= EL + m + 2) begin
                if (lowcnt == 0) snap = din_mem_l2cache;
                else check_line("din_stable", din_mem_l2cache, snap);
                lowcnt++;
            end
            @(posedge clk); #1;
            if (lowcnt >= hold) l2cache_mem_rdy = 1'b1;
        end
        l2cache_mem_rdy = 1'b1;
        check("dataok_seen", 32'(got), 32'd1);
    endtask

    task automatic do_write(input logic [31:0] a, input bit suc, input logic [3:0] strb,
                            input logic [LW-1:0] line);
        int t0;
        int m;
        int b;
        m = suc ? 1 : N;
        b = m_base(a, suc);
        log_q.delete();
        addr_l2cache_mem_w = a;
        l2cache_mem_SUC    = suc;
        l2cache_mem_wstrb  = strb;
        dout_l2cache_mem   = line;
        l2cache_mem_req_w  = 1'b1;
        wait_addrok(1'b1, t0);
        l2cache_mem_req_w  = 1'b0;
        l2cache_mem_SUC    = 1'b0;
        m_write(a, suc, strb, line);
        for (int n = 0; n < 100 && cyc <= t0 + EL + m; n++) begin
            @(posedge clk); #1;
        end
        check("wr_beats", log_q.size(), m);
        for (int j = 0; j < m && j < log_q.size(); j++) begin
            check("wr_cycle", log_q[j].c - t0, EL + 1 + j);
            check("wr_addr", 32'(log_q[j].a), b + j);
            check("wr_we", 32'(log_q[j].we), suc ? 32'(strb) : 32'hF);
            check("wr_data", log_q[j].d, suc ? line[31:0] : line[32*j +: 32]);
        end
    endtask

    task automatic do_read(input logic [31:0] a, input bit suc, input int hold,
                           output logic [LW-1:0] line, output int lat);
        int t0;
        int td;
        int m;
        int bad;
        m   = suc ? 1 : N;
        bad = 0;
        log_q.delete();
        addr_l2cache_mem_r = a;
        l2cache_mem_SUC    = suc;
        l2cache_mem_req_r  = 1'b1;
        wait_addrok(1'b0, t0);
        l2cache_mem_req_r  = 1'b0;
        l2cache_mem_SUC    = 1'b0;
        wait_dataok(t0, m, hold, line, td);
        lat = td - t0;
        check_line("rd_line", line, m_read(a, suc));
        foreach (log_q[j]) if (log_q[j].we != 4'h0) bad++;
        check("rd_beats", log_q.size(), m);
        check("rd_we_zero", bad, 0);
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        bit          suc;
        logic [3:0]  strb;
        logic [31:0] d0;
        int          hold;
        logic [31:0] exp_lane0;
        int          exp_lat;
    } vec_t;

    vec_t          tbl [10];
    logic [LW-1:0] line;
    int            lat;
    int            t0w;
    int            t0r;
    int            td;
    int            cnt;
    logic [31:0]   a;
    bit            suc;
    logic [3:0]    strb;
    int            hold;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            tb_ram[i]  = '0;
            ref_mem[i] = '0;
        end

        // Directed vectors: {wr, addr, suc, wstrb, lane0 data, rdy hold, exp lane0, exp latency}
        tbl[0] = '{1'b1, 32'h0000_1040, 1'b0, 4'hF, 32'h0000_0100, 0, 32'h0,         0};
        tbl[1] = '{1'b0, 32'h0000_1044, 1'b0, 4'h0, 32'h0,         0, 32'h0000_0100, 12};
        tbl[2] = '{1'b1, 32'h0000_2006, 1'b1, 4'hF, 32'h1111_2222, 0, 32'h0,         0};
        tbl[3] = '{1'b1, 32'h0000_2006, 1'b1, 4'hC, 32'hAABB_CCDD, 0, 32'h0,         0};
        tbl[4] = '{1'b0, 32'h0000_2006, 1'b1, 4'h0, 32'h0,         0, 32'hAABB_2222, 5};
        tbl[5] = '{1'b0, 32'h0000_2000, 1'b0, 4'h0, 32'h0,         5, 32'h0,         17};
        tbl[6] = '{1'b1, 32'h0004_0008, 1'b1, 4'hF, 32'hDEAD_BEEF, 0, 32'h0,         0};
        tbl[7] = '{1'b0, 32'h0000_0008, 1'b1, 4'h0, 32'h0,         0, 32'hDEAD_BEEF, 5};
        tbl[8] = '{1'b1, 32'h0003_FFE4, 1'b0, 4'hF, 32'h0000_0900, 0, 32'h0,         0};
        tbl[9] = '{1'b0, 32'h0003_FFFC, 1'b1, 4'h0, 32'h0,         2, 32'h0000_0907, 7};

        // Reset held with a pending read: everything quiet, nothing accepted
        rstn = 1'b0;
        addr_l2cache_mem_r = 32'h0000_0040;
        l2cache_mem_req_r  = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("reset_ctrl", 32'({mem_l2cache_addrOK_r, mem_l2cache_addrOK_w, mem_l2cache_dataOK,
                                     ram_en, ram_we, ram_addr}), 32'h0);
            check("reset_wdata", ram_wdata, 32'h0);
            check_line("reset_din", din_mem_l2cache, '0);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        do_read(32'h0000_0040, 1'b0, 0, line, lat);

        // Table-driven directed sequence
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].wr) begin
                for (int j = 0; j < N; j++)
                    line[32*j +: 32] = tbl[i].suc ? tbl[i].d0 : tbl[i].d0 + 32'(j);
                do_write(tbl[i].addr, tbl[i].suc, tbl[i].strb, line);
            end else begin
                do_read(tbl[i].addr, tbl[i].suc, tbl[i].hold, line, lat);
                check("tbl_lane0", line[31:0], tbl[i].exp_lane0);
                check("tbl_latency", lat, tbl[i].exp_lat);
            end
        end

        // Read and write raised together: write first, read on the next free cycle
        for (int j = 0; j < N; j++) line[32*j +: 32] = 32'h5000 + 32'(j);
        addr_l2cache_mem_w = 32'h0000_3000;
        addr_l2cache_mem_r = 32'h0000_3000;
        dout_l2cache_mem   = line;
        l2cache_mem_SUC    = 1'b0;
        l2cache_mem_req_w  = 1'b1;
        l2cache_mem_req_r  = 1'b1;
        wait_addrok(1'b1, t0w);
        l2cache_mem_req_w  = 1'b0;
        m_write(32'h0000_3000, 1'b0, 4'hF, line);
        wait_addrok(1'b0, t0r);
        l2cache_mem_req_r  = 1'b0;
        check("both_read_accept", t0r - t0w, EL + N + 1);
        wait_dataok(t0r, N, 0, line, td);
        check("both_read_latency", td - t0r, EL + N + 2);
        check_line("both_read_line", line, m_read(32'h0000_3000, 1'b0));

        // Reset in the middle of a read: transaction dropped, no response
        addr_l2cache_mem_r = 32'h0000_1040;
        l2cache_mem_req_r  = 1'b1;
        wait_addrok(1'b0, t0r);
        l2cache_mem_req_r  = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        rstn = 1'b0;
        @(negedge clk);
        check("abort_outs", 32'({ram_en, ram_we, ram_addr, mem_l2cache_dataOK}), 32'h0);
        check_line("abort_din", din_mem_l2cache, '0);
        @(posedge clk); #1;
        rstn = 1'b1;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (mem_l2cache_dataOK || ram_en) cnt++;
            @(posedge clk); #1;
        end
        check("abort_quiet", cnt, 0);

        // Randomised traffic against the reference memory
        for (int i = 0; i < 40; i++) begin
            a    = ($urandom_range(0, 7) << 18) | ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
            suc  = 1'($urandom_range(0, 1));
            strb = 4'($urandom);
            hold = $urandom_range(0, 3);
            for (int j = 0; j < N; j++) line[32*j +: 32] = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, suc, strb, line);
            end else begin
                do_read(a, suc, hold, line, lat);
                check("rand_latency", lat, EL + (suc ? 1 : N) + 2 + hold);
            end
        end

        check("no_dual_addrok", dual_cnt, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
